// File: rtl/reg_file.sv
// Architectural register file with per-register pending-write scoreboard; r0 hardwired to zero.
// Optional same-cycle writeback bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic              issue_ready
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    logic retire_en;
    logic retire_dec;
    logic issue_acc;

    always_comb begin
        retire_en   = reg_write && (write_reg != '0);
        retire_dec  = retire_en && (pend_q[write_reg] != '0);
        // A full counter can still accept when this cycle's retire frees a slot.
        issue_ready = !((issue_dest != '0) && (pend_q[issue_dest] == PEND_MAX) &&
                        !(retire_en && (write_reg == issue_dest)));
        issue_acc   = issue_valid && issue_ready && (issue_dest != '0);
    end

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int i = 1; i < NREG; i++) begin
            if (retire_en && (write_reg == ADDR_W'(i))) begin
                regs_d[i] = write_data;
            end
            if ((issue_acc && (issue_dest == ADDR_W'(i))) &&
                !(retire_dec && (write_reg == ADDR_W'(i)))) begin
                pend_d[i] = pend_q[i] + PEND_W'(1);
            end else if (!(issue_acc && (issue_dest == ADDR_W'(i))) &&
                         (retire_dec && (write_reg == ADDR_W'(i)))) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
        regs_d[0] = '0;
        pend_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    always_comb begin
        hit1 = retire_en && (write_reg == read_reg1);
        hit2 = retire_en && (write_reg == read_reg2);

        if (read_reg1 == '0)   read_data1 = '0;
        else if (hit1)         read_data1 = write_data;
        else                   read_data1 = regs_q[read_reg1];

        if (read_reg2 == '0)   read_data2 = '0;
        else if (hit2)         read_data2 = write_data;
        else                   read_data2 = regs_q[read_reg2];

        // A retire landing this cycle frees one pending slot as seen by decode.
        busy1 = hit1 ? (pend_q[read_reg1] > PEND_W'(1)) : (pend_q[read_reg1] != '0);
        busy2 = hit2 ? (pend_q[read_reg2] > PEND_W'(1)) : (pend_q[read_reg2] != '0);
    end
`else
    always_comb begin
        read_data1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
        read_data2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];
        busy1      = (pend_q[read_reg1] != '0);
        busy2      = (pend_q[read_reg2] != '0);
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed checks of reg_file against an array/integer reference model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        busy1;
    logic        busy2;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [32];
    int          mpend [32];
    localparam int PMAX = 3;

    reg_file dut (
        .clk(clk), .rst(rst),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .busy1(busy1), .busy2(busy2),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit retiring(input logic [4:0] r);
        return reg_write && (write_reg != 0) && (write_reg == r);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] r);
        if (r == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (retiring(r)) return write_data;
`endif
        return mregs[r];
    endfunction

    function automatic logic exp_busy(input logic [4:0] r);
        int n;
        n = mpend[r];
`ifdef REGFILE_BYPASS_EN
        if (retiring(r) && n > 0) n = n - 1;
`endif
        return n != 0;
    endfunction

    function automatic logic exp_ready();
        if (issue_dest == 0) return 1'b1;
        if (mpend[issue_dest] < PMAX) return 1'b1;
        return retiring(issue_dest);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'h0;
            mpend[i] = 0;
        end
    endtask

    task automatic idle();
        rst = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'h0;
        issue_valid = 1'b0; issue_dest = 5'd0;
    endtask

    // Check outputs at negedge, advance the model, then step past the next posedge.
    task automatic step();
        logic rdy;
        @(negedge clk);
        rdy = exp_ready();
        chk("read_data1", read_data1, exp_rd(read_reg1));
        chk("read_data2", read_data2, exp_rd(read_reg2));
        chk("busy1", busy1, exp_busy(read_reg1));
        chk("busy2", busy2, exp_busy(read_reg2));
        chk("issue_ready", issue_ready, rdy);
        if (rst) begin
            clear_model();
        end else begin
            if (reg_write && write_reg != 0) begin
                mregs[write_reg] = write_data;
                if (mpend[write_reg] > 0) mpend[write_reg]--;
            end
            if (issue_valid && rdy && issue_dest != 0) mpend[issue_dest]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] d);
        idle(); issue_valid = 1'b1; issue_dest = d; step();
    endtask

    task automatic retire(input logic [4:0] d, input logic [31:0] v);
        idle(); reg_write = 1'b1; write_reg = d; write_data = v; step();
    endtask

    initial begin
        idle();
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        idle();

        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i); step();
        end

        read_reg1 = 5'd5; read_reg2 = 5'd0;
        retire(5'd5, 32'hDEADBEEF);
        retire(5'd0, 32'h00001234);
        idle(); step();
        chk("r5_value", read_data1, 32'hDEADBEEF);
        chk("r0_value", read_data2, 32'h0);

        read_reg1 = 5'd7;
        retire(5'd7, 32'hA5A5A5A5);
        idle(); step();
        chk("r7_next", read_data1, 32'hA5A5A5A5);

        read_reg1 = 5'd3; read_reg2 = 5'd9;
        issue(5'd3); issue(5'd3); issue(5'd3);
        idle(); issue_valid = 1'b1; issue_dest = 5'd3;
        #1 chk("ready_full", issue_ready, 1'b0);
        step();
        idle(); issue_valid = 1'b1; issue_dest = 5'd3;
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h33;
        #1 chk("ready_full_retire", issue_ready, 1'b1);
        step();
        chk("pend3_full", 64'(mpend[3]), 64'd3);
        retire(5'd3, 32'h1); retire(5'd3, 32'h2);
        idle(); step();
        chk("busy3_last", busy1, 1'b1);
        retire(5'd3, 32'h3);
        idle(); step();
        chk("busy3_clear", busy1, 1'b0);

        retire(5'd9, 32'h99);
        idle(); step();
        chk("busy9_zero", busy2, 1'b0);
        issue(5'd9);
        idle(); issue_valid = 1'b1; issue_dest = 5'd9;
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h999;
        step();
        idle(); step();
        chk("busy9_held", busy2, 1'b1);
        retire(5'd9, 32'h9);

        read_reg1 = 5'd4;
        retire(5'd4, 32'h44); issue(5'd4);
        idle(); rst = 1'b1; reg_write = 1'b1; write_reg = 5'd4; write_data = 32'h4444;
        issue_valid = 1'b1; issue_dest = 5'd4;
        step();
        idle(); step();
        chk("r4_after_rst", read_data1, 32'h0);
        chk("busy4_after_rst", busy1, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            reg_write   = $urandom_range(0, 1) == 1;
            write_reg   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            write_data  = $urandom;
            issue_valid = $urandom_range(0, 2) != 0;
            issue_dest  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            read_reg1   = ($urandom_range(0, 1) == 0) ? write_reg : 5'($urandom_range(0, 7));
            read_reg2   = ($urandom_range(0, 1) == 0) ? issue_dest : 5'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file and pending-write scoreboard for the 5-stage pipeline; the write side consumes the writeback stage's `reg_write`/`write_data` pair plus the destination index carried down the pipe. It supplies two operand read ports to decode, tracks in-flight writes per register so decode can stall on RAW hazards, and hardwires register 0 to zero.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width (2^ADDR_W registers)
- `PEND_W`, 2, width of each per-register pending-write counter

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `reg_write`  in  1  writeback write enable
- `write_reg`  in  ADDR_W  writeback destination index
- `write_data`  in  DATA_W  writeback data
- `read_reg1`  in  ADDR_W  read port 1 index
- `read_reg2`  in  ADDR_W  read port 2 index
- `read_data1`  out  DATA_W  read port 1 data (combinational)
- `read_data2`  out  DATA_W  read port 2 data (combinational)
- `busy1`  out  1  register at `read_reg1` has an outstanding write
- `busy2`  out  1  register at `read_reg2` has an outstanding write
- `issue_valid`  in  1  decode issues an instruction that will write `issue_dest`
- `issue_dest`  in  ADDR_W  destination of issued instruction
- `issue_ready`  out  1  issue accepted this cycle if `issue_valid`

## Operation
- Storage: 2^ADDR_W × DATA_W registers; register 0 reads 0 always, writes to it discarded.
- Write: on rising edge, if `reg_write` and `write_reg != 0`, `regs[write_reg] <= write_data`.
- Read: `read_dataN = (read_regN == 0) ? 0 : regs[read_regN]`, plus bypass per Configuration.
- Scoreboard: one PEND_W-bit counter `pend[i]` per register; `pend[0]` constant 0.
  - Issue accepted: `issue_valid && issue_ready && issue_dest != 0` → `pend[issue_dest] + 1`.
  - Retire: `reg_write && write_reg != 0 && pend[write_reg] != 0` → `pend[write_reg] - 1`.
  - Accepted issue and retire to same register same cycle → counter unchanged.
  - Retire with counter 0 → data written, counter stays 0 (no underflow).
- `issue_ready = 0` only when `issue_dest != 0` and `pend[issue_dest]` is all-ones and no retire to `issue_dest` this cycle; otherwise 1. Rejected issue changes nothing; decode must hold it.
- `busyN = (pend[read_regN] != 0)`, modified per Configuration.
- Reset: all registers 0, all counters 0.

## Timing
- Reset values: `read_data1/2 = 0`, `busy1/2 = 0`, `issue_ready = 1`.
- Write latency: data written at edge N is visible on read ports from cycle N+1 (same cycle with bypass).
- Scoreboard latency: issue accepted at edge N raises `busy` from cycle N+1.
- `rst` mid-operation: clears all storage and counters at that edge, overriding any simultaneous write or issue.
- Reads, `busy`, `issue_ready` purely combinational from state and current inputs; no combinational path from `issue_*` to `read_data`.

## Configuration
- `REGFILE_BYPASS_EN` defined: if `reg_write && write_reg != 0 && write_reg == read_regN`, `read_dataN = write_data` same cycle, and `busyN` is computed from `pend[read_regN]` minus that retire (i.e. deasserts if counter is 1).
- Not defined: read ports show stored value only; `busyN` from stored counter; decode sees the written value and cleared busy one cycle after writeback.

## Test plan
- Reset, then read all indices → all `read_data = 0`, `busy = 0`, `issue_ready = 1`.
- Write 0xDEADBEEF to r5, read r5 next cycle → 0xDEADBEEF; write 0x1234 to r0, read r0 → 0.
- Bypass: write 0xA5A5A5A5 to r7 while `read_reg1 = 7` → with `REGFILE_BYPASS_EN` same-cycle 0xA5A5A5A5; without it old value, new value next cycle.
- Issue r3 three times (PEND_W=2), fourth issue → `issue_ready = 0`, `pend[3] = 3`; retire r3 same cycle as fourth issue → accepted, counter stays 3; three more retires → `busy` for r3 drops after last.
- Retire to r9 with `pend[9] = 0` → r9 updated, `busy` stays 0; issue+retire r9 same cycle with `pend = 1` → remains 1.
- Assert `rst` with simultaneous write r4 and issue r4 pending → after edge r4 = 0, `pend[4] = 0`, `busy = 0`.
